dmem_mmio_responder: RTL and testbench



---
 rtl/dmem_mmio_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - MA-stage data port responder: word RAM plus TX FIFO / status / cycle counter MMIO
// Optional cycle counter hardware: define DMEM_MMIO_CYCLE_CNT_EN
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  mem_read,
  output logic [31:0] data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);
  localparam int unsigned IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {SZ_NONE = 2'b00, SZ_BYTE = 2'b01, SZ_HALF = 2'b10, SZ_WORD = 2'b11} size_e;
  typedef enum logic [1:0] {REG_TX = 2'd0, REG_STATUS = 2'd1, REG_CYC_LO = 2'd2, REG_CYC_HI = 2'd3} reg_e;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             misalign_q, misalign_d;
  logic [63:0]      cycle_val;

  size_e            acc_size;
  reg_e             reg_sel;
  logic             is_store, in_ram, aligned, mmio_hit;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word, rd_shift, wr_rep, ram_wdata, status;
  logic [3:0]       wr_mask;
  logic             ram_we, push, pop, full, empty, accept;

  // A store takes priority, so its size governs decode, alignment and the error flag.
  always_comb begin
    is_store = (mem_write != SZ_NONE);
    acc_size = size_e'(is_store ? mem_write : mem_read);
    in_ram   = ({1'b0, address} < RAM_BYTES);
    lane     = address[1:0];
    ram_idx  = address[IDX_W+1:2];
    reg_sel  = reg_e'(address[3:2]);
    unique case (acc_size)
      SZ_HALF: aligned = ~address[0];
      SZ_WORD: aligned = (lane == 2'b00);
      default: aligned = 1'b1;
    endcase
    mmio_hit = (address[31:4] == MMIO_BASE[31:4]) && (acc_size == SZ_WORD) && (lane == 2'b00);
    rd_word  = ram_q[ram_idx];
    rd_shift = rd_word >> {lane, 3'b000};
  end

  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    pop        = !empty && tx_ready;
    push       = is_store && mmio_hit && (reg_sel == REG_TX);
    accept     = push && (!full || pop);
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q | (push && !accept);
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = overflow_q;
    status[15:8]  = 8'(count_q);
    tx_valid      = !empty;
    tx_data       = empty ? 8'h00 : fifo_q[rd_ptr_q];
  end

  always_comb begin
    data_out = '0;
    if (!is_store && (acc_size != SZ_NONE) && aligned) begin
      if (in_ram) begin
        unique case (acc_size)
          SZ_BYTE: data_out = {24'b0, rd_shift[7:0]};
          SZ_HALF: data_out = {16'b0, rd_shift[15:0]};
          default: data_out = rd_word;
        endcase
      end else if (mmio_hit) begin
        unique case (reg_sel)
          REG_STATUS: data_out = status;
          REG_CYC_LO: data_out = cycle_val[31:0];
          REG_CYC_HI: data_out = cycle_val[63:32];
          default:    data_out = '0;
        endcase
      end
    end
  end

  // Partial stores read-modify-write the addressed word, replacing only the masked lanes.
  always_comb begin
    unique case (acc_size)
      SZ_BYTE: begin
        wr_mask = 4'b0001 << lane;
        wr_rep  = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        wr_mask = 4'b0011 << lane;
        wr_rep  = {2{data_in[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_rep  = data_in;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      ram_wdata[i*8 +: 8] = wr_mask[i] ? wr_rep[i*8 +: 8] : rd_word[i*8 +: 8];
    end
    ram_we     = is_store && in_ram && aligned;
    misalign_d = misalign_q | ((acc_size != SZ_NONE) && in_ram && !aligned);
  end

  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      for (int i = 0; i < int'(RAM_WORDS); i++) begin
        ram_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      if (ram_we) begin
        ram_q[ram_idx] <= ram_wdata;
      end
      if (accept) begin
        fifo_q[wr_ptr_q] <= data_in[7:0];
      end
    end
  end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
  logic [63:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = 64'd0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - randomized and directed bench for dmem_mmio_responder against a byte-level model
module tb_dmem_mmio_responder;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;
  localparam int          RAM_B = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  mem_write = '0;
  logic [1:0]  mem_read = '0;
  logic [31:0] data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]      mb [RAM_B];
  logic [7:0]      mq [$];
  bit              m_ovf = 1'b0;
  bit              m_mis = 1'b0;
  longint unsigned m_cyc = 0;

  always #5 clk = ~clk;

  dmem_mmio_responder #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .mem_write(mem_write), .mem_read(mem_read), .data_out(data_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .misalign_err(misalign_err)
  );

  function automatic int sz_bytes(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] w, input logic [1:0] r);
    int n;
    logic [31:0] v;
    logic [63:0] cyc;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
    cyc = m_cyc;
`else
    cyc = 64'd0;
`endif
    if (w != 0 || r == 0) return 32'd0;
    n = sz_bytes(r);
    if (a < RAM_B) begin
      if (a % n != 0) return 32'd0;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a + i];
      return v;
    end
    if (r == 2'd3) begin
      if (a == BASE + 4) return exp_status();
      if (a == BASE + 8) return cyc[31:0];
      if (a == BASE + 12) return cyc[63:32];
    end
    return 32'd0;
  endfunction

  task automatic model_edge();
    int n;
    logic [1:0] eff;
    bit pop, push, acc;
    if (reset) begin
      foreach (mb[i]) mb[i] = 8'h00;
      mq.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      m_cyc = 0;
      return;
    end
    m_cyc++;
    eff = (mem_write != 0) ? mem_write : mem_read;
    n = sz_bytes(eff);
    if (n != 0 && address < RAM_B) begin
      if (address % n != 0) m_mis = 1'b1;
      else if (mem_write != 0) for (int i = 0; i < n; i++) mb[address + i] = data_in[8*i +: 8];
    end
    pop  = (mq.size() != 0) && tx_ready;
    push = (mem_write == 2'd3) && (address == BASE);
    acc  = push && ((mq.size() < DEPTH) || pop);
    if (push && !acc) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(data_in[7:0]);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                       input logic [1:0] r, input logic rdy);
    @(negedge clk);
    reset = 1'b0; address = a; data_in = d; mem_write = w; mem_read = r; tx_ready = rdy;
    #1;
  endtask

  task automatic drive_rst(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    reset = 1'b1; address = a; data_in = d; mem_write = w; mem_read = 2'd0; tx_ready = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    drive_rst(32'd0, 32'd0, 2'd0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data_out: got %h want 00000000", data_out); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    tick();
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", data_out); end
    tick();
    drive(32'h3FC, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_ram_clear: got %h want 00000000", data_out); end
    tick();
  endtask

  task automatic test_ram_lanes();
    drive(32'h10, 32'hDEAD_BEEF, 2'd3, 2'd0, 1'b0); tick();
    drive(32'h11, 32'h0000_0055, 2'd1, 2'd0, 1'b0); tick();
    drive(32'h10, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'hDEAD_55EF) begin n_fail++; $display("FAIL lanes_word: got %h want DEAD55EF", data_out); end
    tick();
    drive(32'h13, 32'd0, 2'd0, 2'd1, 1'b0);
    n_checks++; if (data_out !== 32'h0000_00DE) begin n_fail++; $display("FAIL lanes_byte: got %h want 000000DE", data_out); end
    tick();
    drive(32'h12, 32'd0, 2'd0, 2'd2, 1'b0);
    n_checks++; if (data_out !== 32'h0000_DEAD) begin n_fail++; $display("FAIL lanes_half: got %h want 0000DEAD", data_out); end
    tick();
    drive(32'h12, 32'hFFFF_FFFF, 2'd3, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL store_wins_data_out: got %h want 00000000", data_out); end
    tick();
  endtask

  task automatic test_misalign();
    do_reset();
    drive(32'h21, 32'h0000_BEEF, 2'd2, 2'd0, 1'b0);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_before_edge: got %b want 0", misalign_err); end
    tick();
    drive(32'h22, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL misalign_load: got %h want 00000000", data_out); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b want 1", misalign_err); end
    tick();
    drive(32'h20, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL misalign_store_dropped: got %h want 00000000", data_out); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b want 1", misalign_err); end
    tick();
    do_reset();
    drive(32'h22, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_reset_clear: got %b want 0", misalign_err); end
    tick();
    drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b0);
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_from_load: got %b want 1", misalign_err); end
    tick();
  endtask

  task automatic test_fifo_fill_drain();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(BASE, 32'h41 + k, 2'd3, 2'd0, 1'b0); tick();
    end
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h0000_0801) begin n_fail++; $display("FAIL fifo_full_status: got %h want 00000801", data_out); end
    n_checks++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_head: got %h/%b want 41/1", tx_data, tx_valid); end
    tick();
    drive(BASE, 32'h49, 2'd3, 2'd0, 1'b0); tick();
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h0000_0805) begin n_fail++; $display("FAIL fifo_overflow_status: got %h want 00000805", data_out); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_head_hold: got %h want 41", tx_data); end
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b1);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + k)) begin n_fail++; $display("FAIL fifo_drain_%0d: got %h/%b want %h/1", k, tx_data, tx_valid, 8'(8'h41 + k)); end
      tick();
    end
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_valid: got %b want 0", tx_valid); end
    n_checks++; if (data_out !== 32'h0000_0006) begin n_fail++; $display("FAIL fifo_empty_status: got %h want 00000006", data_out); end
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want [8];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(BASE, 32'h10 + k, 2'd3, 2'd0, 1'b0); tick();
    end
    drive(BASE, 32'h5A, 2'd3, 2'd0, 1'b1);
    n_checks++; if (tx_data !== 8'h10) begin n_fail++; $display("FAIL fpp_head: got %h want 10", tx_data); end
    tick();
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h0000_0801) begin n_fail++; $display("FAIL fpp_status: got %h want 00000801", data_out); end
    tick();
    for (int k = 0; k < 7; k++) want[k] = 8'(8'h11 + k);
    want[7] = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b1);
      n_checks++; if (tx_data !== want[k]) begin n_fail++; $display("FAIL fpp_order_%0d: got %h want %h", k, tx_data, want[k]); end
      tick();
    end
  endtask

  task automatic test_cycle_and_reset();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(32'd0, 32'd0, 2'd0, 2'd0, 1'b0); tick();
    end
    drive(BASE + 8, 32'd0, 2'd0, 2'd3, 1'b0);
`ifdef DMEM_MMIO_CYCLE_CNT_EN
    n_checks++; if (data_out < 32'd19 || data_out > 32'd21) begin n_fail++; $display("FAIL cycle_lo: got %0d want 20+-1", data_out); end
`else
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL cycle_lo: got %h want 00000000", data_out); end
`endif
    tick();
    drive(BASE + 12, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL cycle_hi: got %h want 00000000", data_out); end
    tick();
    drive(BASE, 32'h61, 2'd3, 2'd0, 1'b0); tick();
    drive(BASE, 32'h62, 2'd3, 2'd0, 1'b0); tick();
    drive_rst(32'h40, 32'hCAFE_F00D, 2'd3); tick();
    drive(32'h40, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_mid_fifo: got %h/%b want 00/0", tx_data, tx_valid); end
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_mid_store: got %h want 00000000", data_out); end
    tick();
  endtask

  task automatic test_unmapped();
    drive(32'd0, 32'h1234_5678, 2'd3, 2'd0, 1'b0); tick();
    drive(32'h8000_0000, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL unmapped_load: got %h want 00000000", data_out); end
    tick();
    drive(32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 2'd0, 1'b0); tick();
    drive(32'h8000_0001, 32'hFFFF_FFFF, 2'd3, 2'd0, 1'b0); tick();
    drive(BASE, 32'h99, 2'd1, 2'd0, 1'b0); tick();
    drive(32'd0, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h1234_5678) begin n_fail++; $display("FAIL unmapped_ram_intact: got %h want 12345678", data_out); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_misalign: got %b want 0", misalign_err); end
    tick();
    drive(BASE + 4, 32'd0, 2'd0, 2'd3, 1'b0);
    n_checks++; if (data_out !== 32'h0000_0002) begin n_fail++; $display("FAIL unmapped_fifo_intact: got %h want 00000002", data_out); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, d, e;
    logic [1:0] w, r;
    logic rdy;
    int kind;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4)      a = $urandom_range(0, 63);
      else if (kind == 5) a = $urandom_range(RAM_B - 8, RAM_B + 7);
      else if (kind <= 7) a = BASE + $urandom_range(0, 5);
      else                a = 32'h8000_0000 | $urandom();
      d   = $urandom();
      w   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      r   = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 79) == 0) begin
        drive_rst(a, d, w);
      end else begin
        drive(a, d, w, r, rdy);
        e = exp_load(a, w, r);
        n_checks++; if (data_out !== e) begin n_fail++; $display("FAIL rand_data_out it=%0d a=%h: got %h want %h", it, a, data_out, e); end
      end
      n_checks++; if (tx_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_tx_valid it=%0d: got %b want %b", it, tx_valid, mq.size() != 0); end
      n_checks++; if (tx_data !== ((mq.size() != 0) ? mq[0] : 8'h00)) begin n_fail++; $display("FAIL rand_tx_data it=%0d: got %h", it, tx_data); end
      n_checks++; if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rand_misalign it=%0d: got %b want %b", it, misalign_err, m_mis); end
      tick();
    end
  endtask

  initial begin
    foreach (mb[i]) mb[i] = 8'h00;
    test_reset();
    test_ram_lanes();
    test_misalign();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_cycle_and_reset();
    test_unmapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
